alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage block of the RV32 single-issue core: decodes the operation from the main-control ALU class and instruction funct fields, selects the second operand (register or immediate), computes the RV32I integer result, and registers it. Sits between the register file / immediate generator and the data-memory / write-back / branch-taken logic.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low (reset==0 clears all registers at the next rising edge).
- en  in  1  result registers update only when 1; hold when 0.
- instruction  in  32  current instruction; uses [14:12] funct3, [31:25] funct7 ([30] = alt bit).
- alu_op  in  4  operation class from control unit (encoding below).
- alu_src  in  1  0: operand B = read_b; 1: operand B = imm.
- read_a  in  32  rs1 value (operand A).
- read_b  in  32  rs2 value.
- imm  in  32  sign-extended immediate.
- result  out  32  registered ALU result.
- zero  out  1  registered (result_next == 0).
- illegal  out  1  registered; 1 when the decode combination is undefined.

## Operation
- Operand mux: B = alu_src ? imm : read_b. A = read_a always.
- alu_op classes: 0000 ADD (load/store/JALR address); 0001 BRANCH; 0010 R-type; 0011 I-type arithmetic; 0100 PASSB (LUI); 0101 AUIPC-style ADD; all other codes -> ADD with illegal=1.
- R-type (funct7=0000000): funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. funct7=0100000: 000 SUB, 101 SRA, others illegal. Any other funct7 illegal (see Configuration).
- I-type: funct3 000 ADDI (instr[30] ignored), 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI, 001 SLLI (funct7 must be 0000000), 101 SRLI (funct7 0000000) / SRAI (funct7 0100000); other funct7 on shifts illegal.
- BRANCH: result = 1 if condition holds else 0. funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 illegal.
- Arithmetic: ADD/SUB modulo 2^32, no overflow flag. Shifts use B[4:0] only. SRA replicates A[31]. SLT/LT/GE signed two's-complement; SLTU/LTU/GEU unsigned. Set results are zero-extended 0/1.
- Illegal combinations: result_next = 0, illegal = 1, zero = 1.

## Timing
- Decode, mux, and ALU fully combinational; result/zero/illegal registered: latency 1 cycle from inputs to outputs.
- Rising edge with reset==0: result=0, zero=1, illegal=0, regardless of en (reset has priority).
- Rising edge with reset==1 and en==1: capture result_next, zero_next, illegal_next.
- en==0: outputs hold prior values; inputs may change freely.
- Reset asserted mid-stream discards the in-flight computation; first valid output is one cycle after en==1 with reset deasserted.
- No handshake; one operation accepted per enabled cycle, full throughput.

## Configuration
- ALU_MUL_EN defined: R-type funct7=0000001 decodes RV32M multiply: funct3 000 MUL (low 32 bits), 001 MULH (signed x signed high), 010 MULHSU (signed A x unsigned B high), 011 MULHU (unsigned high); funct3 1xx (div/rem) illegal. Multiply is combinational inside the same single-cycle path.
- ALU_MUL_EN undefined: funct7=0000001 is illegal (result 0, illegal=1); no multiplier hardware.

## Test plan
- Reset: reset=0 for one edge with arbitrary inputs, en=1 -> result=0, zero=1, illegal=0.
- R-type: alu_op=0010, alu_src=0, A=0x00000005, read_b=0x00000007, funct3=000 funct7=0100000 -> next cycle result=0xFFFFFFFE, zero=0; funct7=0000000 -> 0x0000000C.
- I-type shift/mux: alu_op=0011, alu_src=1, A=0x80000000, imm=0x401 (funct7 0100000, shamt 1), funct3=101 -> result=0xC0000000; read_b value ignored.
- Branch: alu_op=0001, A=0xFFFFFFFF, B=0x00000001: funct3=100 -> result=1; funct3=110 -> result=0, zero=1; funct3=010 -> illegal=1.
- Hold/PASSB: alu_op=0100, alu_src=1, imm=0x12345000, en=1 -> result=0x12345000; then en=0 with new inputs for 3 cycles -> result stays 0x12345000.
- Multiply: R-type funct7=0000001 funct3=011, A=B=0xFFFFFFFF -> with ALU_MUL_EN result=0xFFFFFFFE; without it result=0, illegal=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute-stage ALU with operand mux, funct decode and registered result.
// Define ALU_MUL_EN to add the RV32M multiply group (MUL/MULH/MULHSU/MULHU) to R-type decode.
module alu_exec_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] instruction,
   input  logic [3:0]  alu_op,
   input  logic        alu_src,
   input  logic [31:0] read_a,
   input  logic [31:0] read_b,
   input  logic [31:0] imm,
   output logic [31:0] result,
   output logic        zero,
   output logic        illegal
);
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] a, b, add_r, sub_r, sll_r, srl_r, sra_r, val, result_next;
   logic        lt, ltu, ill;
   assign f3    = instruction[14:12];
   assign f7    = instruction[31:25];
   assign a     = read_a;
   assign b     = alu_src ? imm : read_b;
   assign add_r = a + b;
   assign sub_r = a - b;
   assign sll_r = a << b[4:0];
   assign srl_r = a >> b[4:0];
   assign sra_r = $signed(a) >>> b[4:0];
   assign lt    = $signed(a) < $signed(b);
   assign ltu   = a < b;
`ifdef ALU_MUL_EN
   logic [63:0] mul_ss, mul_su, mul_uu;
   assign mul_ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign mul_su = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
   assign mul_uu = {32'b0, a} * {32'b0, b};
`endif
   always_comb begin
      val = 32'b0;
      ill = 1'b0;
      case (alu_op)
         4'b0000, 4'b0101: val = add_r;
         4'b0100: val = b;
         4'b0001:
            case (f3)
               3'b000:  val = {31'b0, a == b};
               3'b001:  val = {31'b0, a != b};
               3'b100:  val = {31'b0, lt};
               3'b101:  val = {31'b0, !lt};
               3'b110:  val = {31'b0, ltu};
               3'b111:  val = {31'b0, !ltu};
               default: ill = 1'b1;
            endcase
         4'b0010:
            case (f7)
               7'b0000000:
                  case (f3)
                     3'b000:  val = add_r;
                     3'b001:  val = sll_r;
                     3'b010:  val = {31'b0, lt};
                     3'b011:  val = {31'b0, ltu};
                     3'b100:  val = a ^ b;
                     3'b101:  val = srl_r;
                     3'b110:  val = a | b;
                     default: val = a & b;
                  endcase
               7'b0100000: begin
                  val = f3 == 3'b000 ? sub_r : sra_r;
                  ill = f3 != 3'b000 && f3 != 3'b101;
               end
`ifdef ALU_MUL_EN
               7'b0000001: begin
                  val = f3 == 3'b000 ? mul_ss[31:0] :
                        f3 == 3'b001 ? mul_ss[63:32] :
                        f3 == 3'b010 ? mul_su[63:32] : mul_uu[63:32];
                  ill = f3[2];
               end
`endif
               default: ill = 1'b1;
            endcase
         4'b0011:
            case (f3)
               3'b000:  val = add_r;
               3'b010:  val = {31'b0, lt};
               3'b011:  val = {31'b0, ltu};
               3'b100:  val = a ^ b;
               3'b110:  val = a | b;
               3'b111:  val = a & b;
               3'b001: begin
                  val = sll_r;
                  ill = f7 != 7'b0000000;
               end
               default: begin
                  val = f7 == 7'b0000000 ? srl_r : sra_r;
                  ill = f7 != 7'b0000000 && f7 != 7'b0100000;
               end
            endcase
         default: ill = 1'b1;
      endcase
   end
   // Any undefined decode forces a zero result so downstream sees a clean value.
   assign result_next = ill ? 32'b0 : val;
   always_ff @(posedge clk) begin
      if (!reset) begin
         result  <= 32'b0;
         zero    <= 1'b1;
         illegal <= 1'b0;
      end else if (en) begin
         result  <= result_next;
         zero    <= result_next == 32'b0;
         illegal <= ill;
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
   logic        clk = 1'b0, reset = 1'b0, en = 1'b0, alu_src = 1'b0;
   logic [31:0] instruction = 32'b0, read_a = 32'b0, read_b = 32'b0, imm = 32'b0;
   logic [3:0]  alu_op = 4'b0;
   logic [31:0] result;
   logic        zero, illegal;
   int          errors = 0, checks = 0;

   alu_exec_unit dut (
      .clk(clk), .reset(reset), .en(en), .instruction(instruction), .alu_op(alu_op),
      .alu_src(alu_src), .read_a(read_a), .read_b(read_b), .imm(imm),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] o, input logic src, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rb,
                        input logic [31:0] im);
      alu_op      = o;
      alu_src     = src;
      instruction = {f7, 10'b0, f3, 12'b0};
      read_a      = a;
      read_b      = rb;
      imm         = im;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      en    = 1'b1;
      drive(4'b0010, 1'b0, 7'h00, 3'b000, 32'h5, 32'h7, 32'h0);
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
      reset = 1'b1;
   endtask

   task automatic test_rtype;
      drive(4'b0010, 1'b0, 7'h20, 3'b000, 32'h5, 32'h7, 32'h0);
      checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL r_sub got=%h exp=fffffffe", result); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL r_sub_zero got=%b exp=0", zero); end
      drive(4'b0010, 1'b0, 7'h00, 3'b000, 32'h5, 32'h7, 32'h0);
      checks++; if (result !== 32'h0000000C) begin errors++; $display("FAIL r_add got=%h exp=0000000c", result); end
      drive(4'b0010, 1'b0, 7'h00, 3'b010, 32'h80000000, 32'h1, 32'h0);
      checks++; if (result !== 32'h1) begin errors++; $display("FAIL r_slt got=%h exp=1", result); end
      drive(4'b0010, 1'b0, 7'h00, 3'b011, 32'h80000000, 32'h1, 32'h0);
      checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL r_sltu got=%h/%b exp=0/1", result, zero); end
      drive(4'b0010, 1'b0, 7'h00, 3'b001, 32'h1, 32'h24, 32'h0);
      checks++; if (result !== 32'h10) begin errors++; $display("FAIL r_sll got=%h exp=10", result); end
      drive(4'b0010, 1'b0, 7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
      checks++; if (result !== 32'h0FF00FF0) begin errors++; $display("FAIL r_xor got=%h exp=0ff00ff0", result); end
      drive(4'b0010, 1'b0, 7'h20, 3'b110, 32'h1, 32'h2, 32'h0);
      checks++; if (illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL r_bad_f3 got=%b/%h exp=1/0", illegal, result); end
   endtask

   task automatic test_itype;
      drive(4'b0011, 1'b1, 7'h20, 3'b101, 32'h80000000, 32'hDEADBEEF, 32'h401);
      checks++; if (result !== 32'hC0000000 || illegal !== 1'b0) begin errors++; $display("FAIL i_srai got=%h/%b exp=c0000000/0", result, illegal); end
      drive(4'b0011, 1'b1, 7'h00, 3'b101, 32'h80000000, 32'hDEADBEEF, 32'h1);
      checks++; if (result !== 32'h40000000) begin errors++; $display("FAIL i_srli got=%h exp=40000000", result); end
      drive(4'b0011, 1'b1, 7'h20, 3'b000, 32'h10, 32'h0, 32'hFFFFFFFF);
      checks++; if (result !== 32'hF) begin errors++; $display("FAIL i_addi_alt got=%h exp=f", result); end
      drive(4'b0011, 1'b1, 7'h20, 3'b001, 32'h1, 32'h0, 32'h401);
      checks++; if (illegal !== 1'b1 || result !== 32'h0) begin errors++; $display("FAIL i_slli_bad got=%b/%h exp=1/0", illegal, result); end
      drive(4'b0011, 1'b1, 7'h00, 3'b011, 32'h5, 32'h0, 32'hFFFFFFFF);
      checks++; if (result !== 32'h1) begin errors++; $display("FAIL i_sltiu got=%h exp=1", result); end
   endtask

   task automatic test_branch;
      drive(4'b0001, 1'b0, 7'h00, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h0);
      checks++; if (result !== 32'h1) begin errors++; $display("FAIL br_lt got=%h exp=1", result); end
      drive(4'b0001, 1'b0, 7'h00, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h0);
      checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL br_ltu got=%h/%b exp=0/1", result, zero); end
      drive(4'b0001, 1'b0, 7'h00, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0);
      checks++; if (illegal !== 1'b1 || result !== 32'h0) begin errors++; $display("FAIL br_bad got=%b/%h exp=1/0", illegal, result); end
      drive(4'b0001, 1'b0, 7'h00, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h0);
      checks++; if (result !== 32'h1 || illegal !== 1'b0) begin errors++; $display("FAIL br_geu got=%h/%b exp=1/0", result, illegal); end
      drive(4'b0001, 1'b0, 7'h00, 3'b101, 32'hFFFFFFFF, 32'h1, 32'h0);
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL br_ge got=%h exp=0", result); end
      drive(4'b0001, 1'b0, 7'h00, 3'b001, 32'h7, 32'h7, 32'h0);
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL br_ne got=%h exp=0", result); end
   endtask

   task automatic test_passb_hold;
      drive(4'b0100, 1'b1, 7'h00, 3'b000, 32'h11111111, 32'h22222222, 32'h12345000);
      checks++; if (result !== 32'h12345000) begin errors++; $display("FAIL passb got=%h exp=12345000", result); end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(4'b0010, 1'b0, 7'h7F, 3'b010, 32'(i), 32'hABCD, 32'h0);
         checks++; if (result !== 32'h12345000 || zero !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL hold%0d got=%h/%b/%b exp=12345000/0/0", i, result, zero, illegal); end
      end
      en = 1'b1;
   endtask

   task automatic test_misc_ops;
      drive(4'b0101, 1'b1, 7'h00, 3'b000, 32'h00001000, 32'h0, 32'h00002000);
      checks++; if (result !== 32'h00003000) begin errors++; $display("FAIL auipc got=%h exp=00003000", result); end
      drive(4'b1001, 1'b0, 7'h00, 3'b000, 32'h1, 32'h2, 32'h0);
      checks++; if (illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL bad_op got=%b/%h exp=1/0", illegal, result); end
   endtask

   task automatic test_mul;
      drive(4'b0010, 1'b0, 7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
`ifdef ALU_MUL_EN
      checks++; if (result !== 32'hFFFFFFFE || illegal !== 1'b0) begin errors++; $display("FAIL mulhu got=%h/%b exp=fffffffe/0", result, illegal); end
      drive(4'b0010, 1'b0, 7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL mulh got=%h exp=0", result); end
      drive(4'b0010, 1'b0, 7'h01, 3'b000, 32'h00010003, 32'h00000005, 32'h0);
      checks++; if (result !== 32'h0005000F) begin errors++; $display("FAIL mul got=%h exp=0005000f", result); end
`else
      checks++; if (result !== 32'h0 || illegal !== 1'b1) begin errors++; $display("FAIL mulhu_off got=%h/%b exp=0/1", result, illegal); end
`endif
   endtask

   task automatic test_reset_midstream;
      drive(4'b0100, 1'b1, 7'h00, 3'b000, 32'h0, 32'h0, 32'hCAFEF00D);
      reset = 1'b0;
      drive(4'b0100, 1'b1, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0BADBEEF);
      checks++; if (result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL mid_reset got=%h/%b/%b exp=0/1/0", result, zero, illegal); end
      reset = 1'b1;
      drive(4'b0000, 1'b1, 7'h00, 3'b000, 32'h7, 32'h0, 32'h9);
      checks++; if (result !== 32'h10) begin errors++; $display("FAIL post_reset got=%h exp=10", result); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a_v [4] = '{32'h3, 32'hFFFF0000, 32'h00FF00FF, 32'h80000000};
      logic [31:0] b_v [4] = '{32'h4, 32'h0F0F0F0F, 32'h0000FFFF, 32'h1F};
      logic [2:0]  f_v [4] = '{3'b000, 3'b111, 3'b110, 3'b101};
      logic [31:0] e_v [4] = '{32'h7, 32'h0F0F0000, 32'h00FFFFFF, 32'h1};
      for (int i = 0; i < 4; i++) begin
         drive(4'b0010, 1'b0, 7'h00, f_v[i], a_v[i], b_v[i], 32'h0);
         checks++; if (result !== e_v[i]) begin errors++; $display("FAIL b2b%0d got=%h exp=%h", i, result, e_v[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_branch();
      test_passb_hold();
      test_misc_ops();
      test_mul();
      test_reset_midstream();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
